// File: rtl/dot_product_accumulator.sv
// Sums NUM_TERMS strobed products plus a bias into a saturating pre-activation value,
// presenting each finished sum with a one-cycle valid pulse.
module dot_product_accumulator #(
  parameter int PRODUCT_WIDTH = 8,
  parameter int NUM_TERMS     = 16,
  parameter int ACC_WIDTH     = 12,
  parameter int COUNT_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ACC_WIDTH-1:0]     bias_in,
  input  logic [PRODUCT_WIDTH-1:0] product_in,
  input  logic                     load_in,
  output logic                     busy,
  output logic [COUNT_WIDTH-1:0]   term_count,
  output logic [ACC_WIDTH-1:0]     sum_out,
  output logic                     sum_valid,
  output logic                     overflow
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_TERM  = COUNT_WIDTH'(NUM_TERMS - 1);
  localparam logic [COUNT_WIDTH-1:0] TERMS_DONE = COUNT_WIDTH'(NUM_TERMS);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   next_sum;
  logic [ACC_WIDTH-1:0] sat_sum;

  // One extra bit catches the carry out, which pins the result at all-ones.
  assign next_sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, product_in};
  assign sat_sum  = next_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : next_sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      term_count <= '0;
      sum_out    <= '0;
      sum_valid  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= bias_in;
            term_count <= '0;
            overflow   <= 1'b0;
            state      <= ACCUM;
            busy       <= 1'b1;
          end
        end
        ACCUM: begin
          // A start mid-sum abandons the partial result; a coincident product is dropped.
          if (start) begin
            acc        <= bias_in;
            term_count <= '0;
            overflow   <= 1'b0;
          end else if (load_in) begin
            acc <= sat_sum;
            if (next_sum[ACC_WIDTH]) overflow <= 1'b1;
            if (term_count == LAST_TERM) begin
              sum_out    <= sat_sum;
              sum_valid  <= 1'b1;
              term_count <= TERMS_DONE;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              term_count <= term_count + COUNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench: three accumulator configurations (4 terms, 8-bit saturating, 1 term)
// driven with directed vectors; a monitor per instance checks each sum_valid pulse.
module tb_dot_product_accumulator;

  typedef struct {
    logic [11:0] sum;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic        start_a = 0, load_a = 0, start_b = 0, load_b = 0, start_c = 0, load_c = 0;
  logic [11:0] bias_a = 0, bias_c = 0;
  logic [7:0]  bias_b = 0;
  logic [7:0]  prod_a = 0, prod_b = 0, prod_c = 0;

  logic        busy_a, busy_b, busy_c;
  logic [4:0]  count_a, count_b, count_c;
  logic [11:0] sum_a, sum_c;
  logic [7:0]  sum_b;
  logic        valid_a, valid_b, valid_c;
  logic        ovf_a, ovf_b, ovf_c;

  dot_product_accumulator #(.PRODUCT_WIDTH(8), .NUM_TERMS(4), .ACC_WIDTH(12), .COUNT_WIDTH(5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bias_in(bias_a), .product_in(prod_a),
    .load_in(load_a), .busy(busy_a), .term_count(count_a), .sum_out(sum_a),
    .sum_valid(valid_a), .overflow(ovf_a));

  dot_product_accumulator #(.PRODUCT_WIDTH(8), .NUM_TERMS(3), .ACC_WIDTH(8), .COUNT_WIDTH(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bias_in(bias_b), .product_in(prod_b),
    .load_in(load_b), .busy(busy_b), .term_count(count_b), .sum_out(sum_b),
    .sum_valid(valid_b), .overflow(ovf_b));

  dot_product_accumulator #(.PRODUCT_WIDTH(8), .NUM_TERMS(1), .ACC_WIDTH(12), .COUNT_WIDTH(5)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bias_in(bias_c), .product_in(prod_c),
    .load_in(load_c), .busy(busy_c), .term_count(count_c), .sum_out(sum_c),
    .sum_valid(valid_c), .overflow(ovf_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples them cleanly on the next rise.
  task automatic drive(input int i, input logic st, input logic [11:0] b, input logic ld,
                       input logic [7:0] p);
    @(negedge clk);
    case (i)
      0: begin start_a = st; bias_a = b; load_a = ld; prod_a = p; end
      1: begin start_b = st; bias_b = b[7:0]; load_b = ld; prod_b = p; end
      default: begin start_c = st; bias_c = b; load_c = ld; prod_c = p; end
    endcase
  endtask

  task automatic strobe(input int i, input logic [7:0] p);
    drive(i, 1'b0, 12'd0, 1'b1, p);
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 12'd0, 1'b0, 8'd255);
  endtask

  task automatic expect_sum(input int i, input logic [11:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    e.cyc = cyc + 1;
    case (i)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic mon_check(input int i, input logic [11:0] s, input logic o);
    exp_t e;
    int   n;
    case (i)
      0: n = qa.size();
      1: n = qb.size();
      default: n = qc.size();
    endcase
    if (n == 0) begin
      check($sformatf("unexpected_sum_valid_%0d", i), 32'd1, 32'd0);
    end else begin
      case (i)
        0: e = qa.pop_front();
        1: e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      check($sformatf("sum_out_%0d", i), 32'(s), 32'(e.sum));
      check($sformatf("overflow_%0d", i), 32'(o), 32'(e.ovf));
      check($sformatf("latency_%0d", i), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) if (valid_a) mon_check(0, sum_a, ovf_a);
  always @(negedge clk) if (valid_b) mon_check(1, {4'd0, sum_b}, ovf_b);
  always @(negedge clk) if (valid_c) mon_check(2, sum_c, ovf_c);

  initial begin
    // Reset state
    #3;
    check("rst_sum", 32'(sum_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic back-to-back sum: 3+5+7+9
    drive(0, 1'b1, 12'd0, 1'b0, 8'd0);
    strobe(0, 8'd3);
    strobe(0, 8'd5);
    strobe(0, 8'd7);
    strobe(0, 8'd9);
    expect_sum(0, 12'd24, 1'b0);
    idle(0);
    idle(0);
    check("basic_busy_after", 32'(busy_a), 0);
    check("basic_count_after", 32'(count_a), 4);

    // Bias 100 with gaps; idle product of 255 must not be counted
    drive(0, 1'b1, 12'd100, 1'b0, 8'd0);
    idle(0);
    check("gap_busy", 32'(busy_a), 1);
    check("gap_count0", 32'(count_a), 0);
    strobe(0, 8'd10);
    idle(0);
    check("gap_count1", 32'(count_a), 1);
    strobe(0, 8'd20);
    idle(0);
    idle(0);
    check("gap_count2", 32'(count_a), 2);
    check("gap_sum_held", 32'(sum_a), 24);
    strobe(0, 8'd30);
    idle(0);
    idle(0);
    idle(0);
    check("gap_count3", 32'(count_a), 3);
    strobe(0, 8'd40);
    expect_sum(0, 12'd200, 1'b0);
    idle(0);
    idle(0);

    // Restart mid-sum with a coincident product that must be dropped
    drive(0, 1'b1, 12'd0, 1'b0, 8'd0);
    strobe(0, 8'd3);
    strobe(0, 8'd5);
    drive(0, 1'b1, 12'd0, 1'b1, 8'd7);
    idle(0);
    check("restart_count", 32'(count_a), 0);
    check("restart_sum_held", 32'(sum_a), 200);
    strobe(0, 8'd1);
    strobe(0, 8'd2);
    strobe(0, 8'd3);
    strobe(0, 8'd4);
    expect_sum(0, 12'd10, 1'b0);
    idle(0);
    idle(0);

    // Strobes in IDLE are ignored; start with a coincident strobe drops the product
    strobe(0, 8'd50);
    strobe(0, 8'd60);
    idle(0);
    check("idle_count", 32'(count_a), 4);
    check("idle_busy", 32'(busy_a), 0);
    check("idle_sum", 32'(sum_a), 10);
    drive(0, 1'b1, 12'd0, 1'b1, 8'd99);
    strobe(0, 8'd1);
    strobe(0, 8'd1);
    strobe(0, 8'd1);
    strobe(0, 8'd1);
    expect_sum(0, 12'd4, 1'b0);
    idle(0);
    idle(0);

    // Saturation in an 8-bit accumulator: 200+100 overflows, +5 stays pinned
    drive(1, 1'b1, 12'd0, 1'b0, 8'd0);
    strobe(1, 8'd200);
    strobe(1, 8'd100);
    strobe(1, 8'd5);
    expect_sum(1, 12'd255, 1'b1);
    idle(1);
    idle(1);
    check("sat_ovf_sticky", 32'(ovf_b), 1);
    drive(1, 1'b1, 12'd0, 1'b0, 8'd0);
    idle(1);
    check("sat_ovf_cleared", 32'(ovf_b), 0);
    check("sat_sum_held", 32'(sum_b), 255);
    strobe(1, 8'd1);
    strobe(1, 8'd1);
    strobe(1, 8'd1);
    expect_sum(1, 12'd3, 1'b0);
    idle(1);
    // Exactly all-ones is not an overflow
    drive(1, 1'b1, 12'd250, 1'b0, 8'd0);
    strobe(1, 8'd5);
    strobe(1, 8'd0);
    strobe(1, 8'd0);
    expect_sum(1, 12'd255, 1'b0);
    idle(1);
    idle(1);

    // Single-term dot product completes on the first strobe
    drive(2, 1'b1, 12'd5, 1'b0, 8'd0);
    strobe(2, 8'd9);
    expect_sum(2, 12'd14, 1'b0);
    idle(2);
    check("one_term_count", 32'(count_c), 1);
    check("one_term_busy", 32'(busy_c), 0);
    idle(2);

    // Asynchronous reset mid-operation clears everything between edges
    drive(0, 1'b1, 12'd0, 1'b0, 8'd0);
    strobe(0, 8'd3);
    strobe(0, 8'd5);
    idle(0);
    #2;
    reset = 1'b0;
    #1;
    check("amid_sum", 32'(sum_a), 0);
    check("amid_count", 32'(count_a), 0);
    check("amid_busy", 32'(busy_a), 0);
    check("amid_ovf", 32'(ovf_a), 0);
    check("amid_valid", 32'(valid_a), 0);
    check("amid_sum_b", 32'(sum_b), 0);
    @(negedge clk);
    reset = 1'b1;
    strobe(0, 8'd1);
    strobe(0, 8'd2);
    strobe(0, 8'd3);
    strobe(0, 8'd4);
    idle(0);
    idle(0);
    check("post_reset_count", 32'(count_a), 0);
    check("post_reset_sum", 32'(sum_a), 0);

    repeat (3) @(negedge clk);
    check("pending_a", 32'(qa.size()), 0);
    check("pending_b", 32'(qb.size()), 0);
    check("pending_c", 32'(qc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sits directly downstream of the pipelined multiplier in the neuron datapath.
- Consumes the registered product stream (product plus its one-cycle load_out strobe) and sums NUM_TERMS products plus a bias into one neuron pre-activation value.
- Presents the finished sum with a one-cycle valid pulse to the activation/compare stage.
- Products may arrive with arbitrary gaps; only strobed cycles count.

Parameters:
PRODUCT_WIDTH, 8, width of incoming unsigned product (multiplier output width)
NUM_TERMS, 16, number of products summed per dot product (>=1)
ACC_WIDTH, 12, accumulator/sum width (>= PRODUCT_WIDTH)
COUNT_WIDTH, 5, width of term counter (must hold NUM_TERMS)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begin new dot product, load bias
bias_in  input  ACC_WIDTH  unsigned bias sampled on start
product_in  input  PRODUCT_WIDTH  product from multiplier, valid when load_in=1
load_in  input  1  product strobe (multiplier load_out)
busy  output  1  high while accumulating (state ACCUM)
term_count  output  COUNT_WIDTH  products accepted in current dot product
sum_out  output  ACC_WIDTH  last completed sum, held until next completion
sum_valid  output  1  one-cycle pulse when sum_out updates
overflow  output  1  sticky saturation flag for current/last dot product

Behaviour:
- Reset asynchronous, active-low. While reset=0:
  - state=IDLE; acc, term_count, sum_out = 0.
  - sum_valid, overflow, busy = 0.
- Leaving reset is synchronous to the next clk edge.
- States: IDLE, ACCUM. busy is registered and equals (state==ACCUM).
- IDLE:
  - start=1: acc<=bias_in, term_count<=0, overflow<=0, go to ACCUM.
  - load_in without start is ignored (no count, no add).
  - start and load_in in the same cycle: start taken, product dropped.
- ACCUM, load_in=1, start=0:
  - next = acc + zero-extended product_in, computed at ACC_WIDTH+1 bits.
  - If bit ACC_WIDTH of next is set: acc<=all-ones, overflow<=1 (sticky). Otherwise acc<=next.
  - Once acc is saturated it stays all-ones.
  - term_count increments.
- Final term (load_in=1 while term_count==NUM_TERMS-1):
  - sum_out <= the saturated next value.
  - sum_valid<=1 for exactly one cycle.
  - term_count<=NUM_TERMS; state<=IDLE.
  - Latency: sum_valid and sum_out appear on the clk edge after the cycle where the final load_in was sampled, i.e. one edge after the strobe.
- ACCUM, load_in=0: acc and term_count hold.
- ACCUM, start=1 (with or without load_in): abort and restart. acc<=bias_in, term_count<=0, overflow<=0, stay ACCUM. No sum_valid; any coincident product is dropped. sum_out retains the previous completed value.
- NUM_TERMS=1: the first strobe after start completes immediately.
- sum_out and overflow hold their values in IDLE until the next start (overflow clears on start) or the next completion.
- sum_valid is never asserted on two consecutive cycles. Minimum start-to-sum_valid is NUM_TERMS+1 edges.
- Reset asserted mid-operation: all state clears immediately, no sum_valid; products strobed afterwards are ignored until start.

Test Plan:
- Basic sum: NUM_TERMS=4, ACC_WIDTH=12, PRODUCT_WIDTH=8. start with bias_in=0, then strobes 3,5,7,9 back-to-back -> sum_out=24, sum_valid one cycle, one edge after the 4th strobe. overflow=0, busy low after.
- Bias and gaps: bias_in=100; strobes 10,20,30,40 separated by 0-3 idle cycles; non-strobed product_in=255 -> sum_out=200. term_count steps 1..4 only on strobes.
- Saturation: ACC_WIDTH=8, NUM_TERMS=3, bias 0; strobes 200,100,5 -> sum_out=255, overflow=1. Next start clears overflow. Sequence 1,1,1 -> 3, overflow=0.
- Restart: NUM_TERMS=4; after strobes 3,5, start (bias 0) coincident with strobe 7; then 1,2,3,4 -> single sum_valid, sum_out=10. Prior sum_out unchanged until then.
- Reset mid-op: after 2 of 4 strobes, pulse reset low asynchronously, between edges -> all outputs 0 immediately. Later strobes without start -> no sum_valid, term_count stays 0.
- Idle ignore / NUM_TERMS=1: strobes in IDLE -> no change. With NUM_TERMS=1, start bias 5, strobe 9 -> sum_out=14, sum_valid next edge.
